piece_scheduler: RTL

Sequences the 3-bit LFSR piece generator (period 7, seed 3'b001, advances one step per clock while its step input is high) to produce a fair 7-bag stream of Tetris piece IDs 0..6. The block requests LFSR steps, rejects pieces already dealt in the current bag, and buffers accepted pieces in a small preview FIFO. The game FSM pops pieces from this FIFO through a valid/request handshake. It sits between the LFSR and the game controller, and also drives the next-piece preview display.

---
 rtl/piece_scheduler_if.sv | 25 ++
 rtl/piece_scheduler.sv | 110 +++++++++++
 2 files changed

// File: rtl/piece_scheduler_if.sv
// Signals between the piece scheduler, the LFSR piece generator and the game controller.
// The master side is the scheduler; the slave side is the generator/game/display.
interface piece_scheduler_if #(
    parameter int PREVIEW_DEPTH = 3
);
    logic [2:0]                 rng_value;
    logic                       rng_step;
    logic                       freeze;
    logic                       piece_req;
    logic                       piece_valid;
    logic [2:0]                 piece_id;
    logic [3*PREVIEW_DEPTH-1:0] preview_ids;
    logic [2:0]                 preview_count;
    logic [6:0]                 bag_mask;

    modport master (
        input  rng_value, freeze, piece_req,
        output rng_step, piece_valid, piece_id, preview_ids, preview_count, bag_mask
    );

    modport slave (
        output rng_value, freeze, piece_req,
        input  rng_step, piece_valid, piece_id, preview_ids, preview_count, bag_mask
    );
endinterface

// File: rtl/piece_scheduler.sv
// 7-bag piece scheduler: draws LFSR values, rejects pieces already dealt in the bag,
// and queues accepted pieces in a small preview FIFO popped by the game.
module piece_scheduler #(
    parameter int PREVIEW_DEPTH = 3,
    parameter int MAX_RETRY     = 8
) (
    input logic               clk,
    input logic               reset,
    piece_scheduler_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, STEP, SAMPLE, FALLBACK} state_t;

    state_t                        state;
    logic [PREVIEW_DEPTH-1:0][2:0] fifo, fifo_nxt;
    logic [2:0]                    count, count_nxt, count_popped;
    logic [6:0]                    mask, mask_set, mask_nxt;
    logic [7:0]                    mask_ext;
    logic [RW-1:0]                 retry, retry_inc;
    logic                          step;
    logic [2:0]                    cand, lowest, push_val;
    logic                          accept, push, pop;

    // rng_value==0 maps to cand 7, which hits the always-set guard bit and rejects.
    assign mask_ext  = {1'b1, mask};
    assign cand      = bus.rng_value - 3'd1;
    assign accept    = (bus.rng_value != 3'd0) && !mask_ext[cand];
    assign retry_inc = retry + 1'b1;
    assign pop       = bus.piece_req && (count != 3'd0);
    assign push      = ((state == SAMPLE) && accept) || (state == FALLBACK);

    always_comb begin
        lowest = 3'd0;
        for (int p = 6; p >= 0; p--)
            if (!mask[p]) lowest = 3'(p);
    end

    assign push_val = (state == FALLBACK) ? lowest : cand;
    assign mask_set = mask | (7'd1 << push_val);
    assign mask_nxt = !push ? mask : ((mask_set == 7'h7F) ? 7'h00 : mask_set);

    // Pop shifts toward entry 0 first, so a simultaneous push lands at the new tail.
    always_comb begin
        fifo_nxt     = fifo;
        count_popped = count - {2'b00, pop};
        if (pop) begin
            for (int k = 0; k < PREVIEW_DEPTH - 1; k++)
                fifo_nxt[k] = fifo[k+1];
            fifo_nxt[PREVIEW_DEPTH-1] = 3'd0;
        end
        if (push)
            for (int k = 0; k < PREVIEW_DEPTH; k++)
                if (count_popped == 3'(k)) fifo_nxt[k] = push_val;
        count_nxt = count_popped + {2'b00, push};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= 1'b0;
            retry <= '0;
            fifo  <= '0;
            count <= 3'd0;
            mask  <= 7'd0;
        end else begin
            fifo  <= fifo_nxt;
            count <= count_nxt;
            mask  <= mask_nxt;
            case (state)
                IDLE: begin
                    if ((count < 3'(PREVIEW_DEPTH)) && !bus.freeze) begin
                        state <= STEP;
                        step  <= 1'b1;
                    end
                end
                STEP: begin
                    step  <= 1'b0;
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    if (accept) begin
                        retry <= '0;
                        state <= IDLE;
                    end else begin
                        retry <= retry_inc;
                        if (retry_inc == RW'(MAX_RETRY)) begin
                            state <= FALLBACK;
                        end else begin
                            state <= STEP;
                            step  <= 1'b1;
                        end
                    end
                end
                FALLBACK: begin
                    retry <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rng_step      = step;
    assign bus.piece_valid   = (count != 3'd0);
    assign bus.piece_id      = fifo[0];
    assign bus.preview_ids   = fifo;
    assign bus.preview_count = count;
    assign bus.bag_mask      = mask;
endmodule
